// File: rtl/life_row_if.sv
// Row-stream bundle for the life row engine: current-generation rows in, next-generation rows out.
interface life_row_if #(
  parameter int WIDTH = 100
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_row;
  logic [15:0]      out_row_idx;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_row_idx
  );
endinterface

// File: rtl/life_row_engine.sv
// Streaming cellular-automaton engine: consumes one generation row by row and
// emits the next generation in the order 1..HEIGHT-1, 0 with a three-row window.
module life_row_engine #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int WRAP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  birth_mask,
  input  logic [8:0]  survive_mask,
  life_row_if.slave   bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_FLUSH_LAST,
    S_FLUSH_FIRST,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       birth_q, birth_d;
  logic [8:0]       survive_q, survive_d;
  logic [15:0]      row_cnt_q, row_cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] row0_q, row0_d;
  logic [WIDTH-1:0] row1_q, row1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_row_q, out_row_d;
  logic [15:0]      out_idx_q, out_idx_d;
  logic             first_sent_q, first_sent_d;
  logic [15:0]      gen_q, gen_d;

  logic in_ready_c;
  logic in_fire_c;
  logic slot_free_c;

  // Cell lookup with column wrap or dead border outside the row.
  function automatic logic cell_at(input logic [WIDTH-1:0] row, input int c);
    int   cc;
    logic v;
    cc = c;
    if (c < 0) begin
      cc = (WRAP != 0) ? WIDTH - 1 : -1;
    end else if (c >= WIDTH) begin
      cc = (WRAP != 0) ? 0 : -1;
    end
    if (cc < 0) begin
      v = 1'b0;
    end else begin
      v = row[CW'(cc)];
    end
    return v;
  endfunction

  // Next state of the middle row given the rows above and below it.
  function automatic logic [WIDTH-1:0] evolve(
    input logic [WIDTH-1:0] up,
    input logic [WIDTH-1:0] mid,
    input logic [WIDTH-1:0] dn,
    input logic [8:0]       bm,
    input logic [8:0]       sm
  );
    logic [WIDTH-1:0] nxt;
    logic [3:0]       n;
    nxt = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(cell_at(up, c - 1)) + 4'(cell_at(up, c)) + 4'(cell_at(up, c + 1)) +
          4'(cell_at(mid, c - 1)) + 4'(cell_at(mid, c + 1)) +
          4'(cell_at(dn, c - 1)) + 4'(cell_at(dn, c)) + 4'(cell_at(dn, c + 1));
      nxt[CW'(c)] = cell_at(mid, c) ? sm[n] : bm[n];
    end
    return nxt;
  endfunction

  // Input acceptance per state; in STREAM a row is taken only when the output slot can absorb it.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_LOAD:   in_ready_c = 1'b1;
      S_STREAM: in_ready_c = !out_valid_q || bus.out_ready;
      default:  in_ready_c = 1'b0;
    endcase
  end

  assign in_fire_c   = bus.in_valid && in_ready_c;
  assign slot_free_c = !out_valid_q || bus.out_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    birth_d      = birth_q;
    survive_d    = survive_q;
    row_cnt_d    = row_cnt_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    row0_d       = row0_q;
    row1_d       = row1_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_idx_d    = out_idx_q;
    first_sent_d = first_sent_q;
    gen_d        = gen_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          birth_d      = birth_mask;
          survive_d    = survive_mask;
          row_cnt_d    = '0;
          first_sent_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_fire_c) begin
          row_cnt_d = row_cnt_q + 16'd1;
          prev_d    = cur_q;
          cur_d     = bus.in_row;
          if (row_cnt_q == 16'd0) begin
            row0_d = bus.in_row;
          end else begin
            row1_d  = bus.in_row;
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (in_fire_c) begin
          out_row_d   = evolve(prev_q, cur_q, bus.in_row, birth_q, survive_q);
          out_idx_d   = row_cnt_q - 16'd1;
          out_valid_d = 1'b1;
          prev_d      = cur_q;
          cur_d       = bus.in_row;
          row_cnt_d   = row_cnt_q + 16'd1;
          if (row_cnt_q == 16'(HEIGHT - 1)) begin
            state_d = S_FLUSH_LAST;
          end
        end
      end
      S_FLUSH_LAST: begin
        if (slot_free_c) begin
          out_row_d   = evolve(prev_q, cur_q, (WRAP != 0) ? row0_q : '0, birth_q, survive_q);
          out_idx_d   = 16'(HEIGHT - 1);
          out_valid_d = 1'b1;
          state_d     = S_FLUSH_FIRST;
        end
      end
      S_FLUSH_FIRST: begin
        if (!first_sent_q) begin
          if (slot_free_c) begin
            out_row_d    = evolve((WRAP != 0) ? cur_q : '0, row0_q, row1_q, birth_q, survive_q);
            out_idx_d    = 16'd0;
            out_valid_d  = 1'b1;
            first_sent_d = 1'b1;
          end
        end else if (out_valid_q && bus.out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gen_d   = gen_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      birth_q      <= 9'h008;
      survive_q    <= 9'h00C;
      row_cnt_q    <= '0;
      prev_q       <= '0;
      cur_q        <= '0;
      row0_q       <= '0;
      row1_q       <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_idx_q    <= '0;
      first_sent_q <= 1'b0;
      gen_q        <= '0;
    end else begin
      state_q      <= state_d;
      birth_q      <= birth_d;
      survive_q    <= survive_d;
      row_cnt_q    <= row_cnt_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      row0_q       <= row0_d;
      row1_q       <= row1_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_idx_q    <= out_idx_d;
      first_sent_q <= first_sent_d;
      gen_q        <= gen_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = out_idx_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign gen_count       = gen_q;

endmodule
